// File: rtl/cnn_job_scheduler_if.sv
// Handshake and accelerator bus bundle for cnn_job_scheduler.
// Groups the request port, the response port and the CNN write/result port.
// Modport slave is the scheduler's view; modport master is the environment's view.
interface cnn_job_scheduler_if;
    // command request from the execute stage
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_cmd;
    logic [4:0]  req_rd;
    // tagged result back to the pipeline
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    // CNN privacy accelerator port
    logic        cnn_resetn;
    logic [3:0]  cnn_awaddr;
    logic        cnn_awvalid;
    logic        cnn_wvalid;
    logic [31:0] cnn_wdata;
    logic        cnn_inference_done;
    logic [3:0]  cnn_predicted_class;

    modport slave (
        input  req_valid, req_cmd, req_rd, rsp_ready,
               cnn_inference_done, cnn_predicted_class,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
               cnn_resetn, cnn_awaddr, cnn_awvalid, cnn_wvalid, cnn_wdata
    );

    modport master (
        output req_valid, req_cmd, req_rd, rsp_ready,
               cnn_inference_done, cnn_predicted_class,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
               cnn_resetn, cnn_awaddr, cnn_awvalid, cnn_wvalid, cnn_wdata
    );
endinterface

// File: rtl/cnn_job_scheduler.sv
// Queues CNN inference commands and runs them one at a time on the accelerator
// (reset pulse, single write, wait for a done edge or timeout, tagged response).
// Latency: push at T -> ISSUE at T+2+RST_PULSE_CYCLES; done edge at D -> rsp_valid at D+1.
// Backpressure: req_ready drops when the queue holds DEPTH jobs; rsp_ready low holds RESPOND.
// Ports: clk/rst (async, active-high); bus = request, response and accelerator
// signals (slave view); busy = job active or queue non-empty; queue_count = occupancy.
module cnn_job_scheduler #(
    parameter int DEPTH            = 4,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int RST_PULSE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    cnn_job_scheduler_if.slave       bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t state;
    state_t next_state;

    // command queue: {cmd, rd}
    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // current job and sequencing counters
    logic [31:0]   job_cmd;
    logic [4:0]    job_rd;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] wait_cnt;
    logic          done_d;
    logic          done_edge;
    logic          timeout_hit;

    // registered response
    logic [31:0]   rsp_data_q;
    logic [4:0]    rsp_rd_q;
    logic          rsp_err_q;

    assign push        = bus.req_valid && bus.req_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    // Only a low-to-high transition counts, so a done level left over from
    // the previous job can never complete the next one.
    assign done_edge   = bus.cnn_inference_done && !done_d;
    assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // ---------------- command queue ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_cmd, bus.req_rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    next_state = S_RESET;
                end
            end
            S_RESET: begin
                if (pulse_cnt == '0) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge || timeout_hit) begin
                    next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (bus.rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.rsp_valid   = (state == S_RESPOND);
        // held low by the block reset as well, so the accelerator restarts with us
        bus.cnn_resetn  = !rst && (state != S_RESET);
        bus.cnn_awvalid = (state == S_ISSUE);
        bus.cnn_wvalid  = (state == S_ISSUE);
        bus.cnn_wdata   = (state == S_ISSUE) ? job_cmd : 32'd0;
        bus.cnn_awaddr  = 4'h0;
    end

    assign bus.req_ready = (count < CW'(DEPTH));
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != S_IDLE) || (count != '0);
    assign queue_count   = count;

    // ---------------- job datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cmd    <= '0;
            job_rd     <= '0;
            pulse_cnt  <= '0;
            wait_cnt   <= '0;
            done_d     <= 1'b0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            done_d <= bus.cnn_inference_done;

            if (pop) begin
                {job_cmd, job_rd} <= mem[rd_ptr];
                pulse_cnt         <= PW'(RST_PULSE_CYCLES - 1);
            end

            if ((state == S_RESET) && (pulse_cnt != '0)) begin
                pulse_cnt <= pulse_cnt - PW'(1);
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end

            if (state == S_WAIT) begin
                if (done_edge) begin
                    rsp_data_q <= {28'd0, bus.cnn_predicted_class};
                    rsp_err_q  <= (bus.cnn_predicted_class >= 4'd10);
                    rsp_rd_q   <= job_rd;
                end else if (timeout_hit) begin
                    rsp_data_q <= 32'hFFFF_FFFF;
                    rsp_err_q  <= 1'b1;
                    rsp_rd_q   <= job_rd;
                end else begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_job_scheduler.sv
module tb_cnn_job_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_cmd = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_ready = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  cls = '0;

    logic        busy_a, busy_b;
    logic [2:0]  qc_a, qc_b;

    int n_checks = 0;
    int n_fail   = 0;

    // ISSUE monitor on the main instance
    int low_run = 0;
    int issue_pulse = 0;
    int issue_cnt = 0;

    always #5 clk = ~clk;

    cnn_job_scheduler_if ifa ();
    cnn_job_scheduler_if ifb ();

    assign ifa.req_valid           = req_valid;
    assign ifa.req_cmd             = req_cmd;
    assign ifa.req_rd              = req_rd;
    assign ifa.rsp_ready           = rsp_ready;
    assign ifa.cnn_inference_done  = done;
    assign ifa.cnn_predicted_class = cls;
    assign ifb.req_valid           = req_valid;
    assign ifb.req_cmd             = req_cmd;
    assign ifb.req_rd              = req_rd;
    assign ifb.rsp_ready           = rsp_ready;
    assign ifb.cnn_inference_done  = done;
    assign ifb.cnn_predicted_class = cls;

    cnn_job_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(4096), .RST_PULSE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .queue_count(qc_a)
    );

    cnn_job_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(16), .RST_PULSE_CYCLES(2)) u_dut_to (
        .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .queue_count(qc_b)
    );

    always @(posedge clk) begin
        #2;
        if (rst) begin
            low_run = 0;
        end else if (!ifa.cnn_resetn) begin
            low_run = low_run + 1;
        end else if (ifa.cnn_awvalid) begin
            issue_pulse = low_run;
            low_run = 0;
            issue_cnt = issue_cnt + 1;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; done = 1'b0; cls = '0;
        step; step;
        rst = 1'b0;
    endtask

    task automatic wait_issue(input bit on_b, input string name);
        int k = 0;
        while (!(on_b ? ifb.cnn_awvalid : ifa.cnn_awvalid) && k < 40) begin
            step; k++;
        end
        n_checks++;
        if (k >= 40) begin
            n_fail++;
            $display("FAIL %s: no ISSUE cycle seen within 40 cycles, required one", name);
        end
    endtask

    task automatic wait_rsp(input bit on_b, input string name);
        int k = 0;
        while (!(on_b ? ifb.rsp_valid : ifa.rsp_valid) && k < 40) begin
            step; k++;
        end
        n_checks++;
        if (k >= 40) begin
            n_fail++;
            $display("FAIL %s: rsp_valid not seen within 40 cycles, required", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        n_checks++;
        if ({ifa.req_ready, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err} !== {1'b1, 1'b0, 32'd0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h required %h",
                     {ifa.req_ready, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err}, {1'b1, 1'b0, 32'd0, 5'd0, 1'b0});
        end
        n_checks++;
        if ({ifa.cnn_resetn, ifa.cnn_awvalid, ifa.cnn_wvalid, ifa.cnn_wdata, ifa.cnn_awaddr} !== {1'b0, 1'b0, 1'b0, 32'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_cnn: got %h required %h",
                     {ifa.cnn_resetn, ifa.cnn_awvalid, ifa.cnn_wvalid, ifa.cnn_wdata, ifa.cnn_awaddr}, {1'b0, 1'b0, 1'b0, 32'd0, 4'd0});
        end
        n_checks++;
        if ({busy_a, qc_a} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_status: busy/count got %h required %h", {busy_a, qc_a}, 4'h0);
        end
        rst = 1'b0;
        step;
        n_checks++;
        if ({ifa.cnn_resetn, busy_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: resetn/busy got %b required 10", {ifa.cnn_resetn, busy_a});
        end
    endtask

    task automatic test_single_job;
        int base;
        bit seen;
        apply_reset;
        base = issue_cnt;
        req_valid = 1'b1; req_cmd = 32'h0012_3456; req_rd = 5'd5;
        step;                               // T+1
        req_valid = 1'b0;
        n_checks++;
        if ({qc_a, ifa.cnn_resetn} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_queued: count/resetn got %h required %h", {qc_a, ifa.cnn_resetn}, {3'd1, 1'b1});
        end
        step;                               // T+2
        n_checks++;
        if (ifa.cnn_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse1: cnn_resetn got %b required 0", ifa.cnn_resetn);
        end
        step;                               // T+3
        n_checks++;
        if ({ifa.cnn_resetn, ifa.cnn_awvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_pulse2: resetn/awvalid got %b required 00", {ifa.cnn_resetn, ifa.cnn_awvalid});
        end
        step;                               // T+4: ISSUE
        n_checks++;
        if ({ifa.cnn_awvalid, ifa.cnn_wvalid, ifa.cnn_wdata, ifa.cnn_awaddr, ifa.cnn_resetn} !== {1'b1, 1'b1, 32'h0012_3456, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got %h required %h",
                     {ifa.cnn_awvalid, ifa.cnn_wvalid, ifa.cnn_wdata, ifa.cnn_awaddr, ifa.cnn_resetn}, {1'b1, 1'b1, 32'h0012_3456, 4'h0, 1'b1});
        end
        step;                               // T+5: WAIT
        n_checks++;
        if ({ifa.cnn_awvalid, ifa.cnn_wdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL single_after_issue: awvalid/wdata got %h required 0", {ifa.cnn_awvalid, ifa.cnn_wdata});
        end
        seen = 1'b0;
        for (int k = 0; k < 19; k++) begin
            step;
            if (ifa.rsp_valid || ifa.cnn_awvalid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_quiet: rsp_valid/awvalid seen during WAIT, got 1 required 0");
        end
        done = 1'b1; cls = 4'd7;            // edge 20 cycles after ISSUE
        step;
        n_checks++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err} !== {1'b1, 32'd7, 5'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got %h required %h",
                     {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err}, {1'b1, 32'd7, 5'd5, 1'b0});
        end
        n_checks++;
        if (issue_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL single_issue_count: got %0d required 1", issue_cnt - base);
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0; done = 1'b0;
        n_checks++;
        if ({ifa.rsp_valid, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done: rsp_valid/busy got %b required 00", {ifa.rsp_valid, busy_a});
        end
    endtask

    task automatic test_queue_full;
        logic [2:0]  exp_cnt [5];
        logic [3:0]  cls_tab [5];
        logic        err_tab [5];
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        cls_tab = '{4'd9, 4'd10, 4'd15, 4'd0, 4'd3};
        err_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_cmd = 32'hA000_0000 + i; req_rd = 5'(i + 1);
            n_checks++;
            if (ifa.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL queue_ready_%0d: got %b required 1", i, ifa.req_ready);
            end
            step;
            n_checks++;
            if (qc_a !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL queue_count_%0d: got %0d required %0d", i, qc_a, exp_cnt[i]);
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (ifa.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL queue_full_ready: got %b required 0", ifa.req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_issue(1'b0, "queue_issue");
                n_checks++;
                if (ifa.cnn_wdata !== 32'hA000_0000 + i) begin
                    n_fail++;
                    $display("FAIL queue_wdata_%0d: got %h required %h", i, ifa.cnn_wdata, 32'hA000_0000 + i);
                end
            end
            n_checks++;
            if (issue_pulse !== 2) begin
                n_fail++;
                $display("FAIL queue_pulse_%0d: resetn low cycles got %0d required 2", i, issue_pulse);
            end
            step; step;
            done = 1'b1; cls = cls_tab[i];
            wait_rsp(1'b0, "queue_rsp");
            n_checks++;
            if ({ifa.rsp_rd, ifa.rsp_data, ifa.rsp_err} !== {5'(i + 1), {28'd0, cls_tab[i]}, err_tab[i]}) begin
                n_fail++;
                $display("FAIL queue_order_%0d: got %h required %h", i,
                         {ifa.rsp_rd, ifa.rsp_data, ifa.rsp_err}, {5'(i + 1), {28'd0, cls_tab[i]}, err_tab[i]});
            end
            rsp_ready = 1'b1;
            step;
            rsp_ready = 1'b0; done = 1'b0;
        end
        n_checks++;
        if ({busy_a, qc_a} !== 4'h0) begin
            n_fail++;
            $display("FAIL queue_drained: busy/count got %h required 0", {busy_a, qc_a});
        end
    endtask

    task automatic test_timeout;
        bit early;
        apply_reset;
        req_valid = 1'b1; req_cmd = 32'h0000_0901; req_rd = 5'd9;
        step;
        req_cmd = 32'h0000_0A02; req_rd = 5'd10;
        step;
        req_valid = 1'b0;
        wait_issue(1'b1, "timeout_issue");
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step;
            if (ifb.rsp_valid) early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: rsp_valid within 16 WAIT cycles, got 1 required 0");
        end
        step;
        n_checks++;
        if ({ifb.rsp_valid, ifb.rsp_data, ifb.rsp_rd, ifb.rsp_err} !== {1'b1, 32'hFFFF_FFFF, 5'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_rsp: got %h required %h",
                     {ifb.rsp_valid, ifb.rsp_data, ifb.rsp_rd, ifb.rsp_err}, {1'b1, 32'hFFFF_FFFF, 5'd9, 1'b1});
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        wait_issue(1'b1, "timeout_next_issue");
        n_checks++;
        if (ifb.cnn_wdata !== 32'h0000_0A02) begin
            n_fail++;
            $display("FAIL timeout_next_wdata: got %h required 00000a02", ifb.cnn_wdata);
        end
        step; step;
        done = 1'b1; cls = 4'd3;
        wait_rsp(1'b1, "timeout_next_rsp");
        n_checks++;
        if ({ifb.rsp_rd, ifb.rsp_data, ifb.rsp_err} !== {5'd10, 32'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_next: got %h required %h", {ifb.rsp_rd, ifb.rsp_data, ifb.rsp_err}, {5'd10, 32'd3, 1'b0});
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0; done = 1'b0;
    endtask

    task automatic test_stale_done;
        bit seen;
        apply_reset;
        req_valid = 1'b1; req_cmd = 32'h0000_0301; req_rd = 5'd3;
        step;
        req_cmd = 32'h0000_0402; req_rd = 5'd4;
        step;
        req_valid = 1'b0;
        wait_issue(1'b0, "stale_issue_a");
        step; step;
        done = 1'b1; cls = 4'd12;
        step;
        n_checks++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err} !== {1'b1, 32'd12, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL invalid_class: got %h required %h",
                     {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err}, {1'b1, 32'd12, 5'd3, 1'b1});
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;                   // done stays high into the next job
        wait_issue(1'b0, "stale_issue_b");
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step;
            if (ifa.rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_done: job completed on a held done level, got 1 required 0");
        end
        done = 1'b0;
        step;
        done = 1'b1; cls = 4'd5;
        step;
        n_checks++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err} !== {1'b1, 32'd5, 5'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL stale_fresh_edge: got %h required %h",
                     {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err}, {1'b1, 32'd5, 5'd4, 1'b0});
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0; done = 1'b0;
    endtask

    task automatic test_backpressure;
        apply_reset;
        req_valid = 1'b1; req_cmd = 32'h0000_0600; req_rd = 5'd6;
        step;
        req_valid = 1'b0;
        wait_issue(1'b0, "bp_issue");
        step; step;
        done = 1'b1; cls = 4'd2;
        step;
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 2) begin
                req_valid = 1'b1; req_cmd = 32'h0000_0700 + k; req_rd = 5'(7 + k);
            end else begin
                req_valid = 1'b0;
            end
            step;
            n_checks++;
            if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err} !== {1'b1, 32'd2, 5'd6, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_stable_%0d: got %h required %h", k,
                         {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_rd, ifa.rsp_err}, {1'b1, 32'd2, 5'd6, 1'b0});
            end
        end
        n_checks++;
        if (qc_a !== 3'd2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d required 2", qc_a);
        end
        rsp_ready = 1'b1;
        step;                               // IDLE, popping
        rsp_ready = 1'b0;
        n_checks++;
        if ({ifa.rsp_valid, ifa.cnn_resetn, qc_a} !== {1'b0, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL bp_idle: got %h required %h", {ifa.rsp_valid, ifa.cnn_resetn, qc_a}, {1'b0, 1'b1, 3'd2});
        end
        step;                               // RESET of next job
        n_checks++;
        if ({ifa.cnn_resetn, qc_a} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL bp_next_start: resetn/count got %h required %h", {ifa.cnn_resetn, qc_a}, {1'b0, 3'd1});
        end
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        apply_reset;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_cmd = 32'h0000_0B00 + i; req_rd = 5'(20 + i);
            step;
        end
        req_valid = 1'b0;
        wait_issue(1'b0, "rst_issue");
        step; step;
        n_checks++;
        if (qc_a !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_pre_count: got %0d required 2", qc_a);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.req_ready, ifa.rsp_valid, ifa.cnn_resetn, ifa.cnn_awvalid, ifa.cnn_wdata, busy_a, qc_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL rst_async: got %h required %h",
                     {ifa.req_ready, ifa.rsp_valid, ifa.cnn_resetn, ifa.cnn_awvalid, ifa.cnn_wdata, busy_a, qc_a},
                     {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 3'd0});
        end
        step;
        rst = 1'b0;
        step;
        n_checks++;
        if ({busy_a, qc_a, ifa.cnn_resetn} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_release: busy/count/resetn got %h required %h", {busy_a, qc_a, ifa.cnn_resetn}, {1'b0, 3'd0, 1'b1});
        end
        done = 1'b1; cls = 4'd4;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step;
            if (ifa.rsp_valid || ifa.cnn_awvalid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_rsp: activity after reset got 1 required 0");
        end
        done = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_job;
        test_queue_full;
        test_timeout;
        test_stale_done;
        test_backpressure;
        test_reset_mid_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
